decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage, directly downstream of fetch. Takes fetch's instr/pc pair, decodes it into a
//  control bundle (regfile addresses, sign-extended immediate, ALU op, mem/branch/jump flags) and
//  holds the bundle in a pipeline register for execute. Valid/ready handshake on both sides with a
//  1-entry skid buffer, so backpressure from execute never drops or duplicates an instruction.
//  Flush from branch resolution empties the stage.
// PARAMETERS
//  XLEN        32   datapath/pc width
//  SKID_EN     1    1: include skid entry (ready_out registered); 0: ready_out = ex_ready_in | !valid_out
// PORTS
//  clk_in            in   1     clock; single clock domain, posedge
//  rst_in            in   1     synchronous reset, active-high
//  instr_valid_in    in   1     fetch holds a valid instr_in/pc_in this cycle
//  instr_in          in   32    instruction word from fetch
//  pc_in             in   XLEN  pc of instr_in
//  ready_out         out  1     stage can accept an instruction this cycle
//  flush_in          in   1     branch mispredicted: discard all held and incoming instructions
//  ex_ready_in       in   1     execute accepts the bundle this cycle
//  valid_out         out  1     bundle on outputs is valid
//  pc_out            out  XLEN  pc of decoded instruction
//  rs1_addr_out      out  5     instr[19:15]
//  rs2_addr_out      out  5     instr[24:20]
//  rd_addr_out       out  5     instr[11:7]
//  imm_out           out  XLEN  sign-extended immediate (I/S/B/U/J), 0 for R-type
//  alu_op_out        out  4     alu_op_e from package
//  alu_src_imm_out   out  1     operand B = imm_out
//  reg_write_out     out  1     writes rd (forced 0 if rd==0 or illegal)
//  mem_read_out      out  1     load;  mem_write_out  out 1  store
//  mem_size_out      out  3     funct3 passthrough for loads/stores
//  branch_out        out  1     conditional branch; jump_out out 1 JAL/JALR
//  illegal_out       out  1     unrecognised opcode/funct
// BEHAVIOUR
//  - Reset: valid_out=0, all bundle outputs 0, skid empty, ready_out=1 in the cycle after rst_in drops.
//    Reset mid-operation discards output reg and skid contents; no partial bundle survives.
//  - Accept: instr_valid_in & ready_out. Latency 1: accepted at edge N -> valid_out at N+1.
//  - ready_out = !skid_valid (registered state only; no combinational path from ex_ready_in).
//  - Output reg loads when !valid_out | ex_ready_in: from skid if skid_valid, else from decoder.
//  - Accept while valid_out & !ex_ready_in -> decoded bundle goes to skid; skid_valid=1, ready_out=0.
//  - valid_out & !ex_ready_in: all outputs held stable bit-for-bit.
//  - Order preserved: skid entry always issues before any newer instruction.
//  - flush_in: at the edge, valid_out<=0, skid_valid<=0; the input presented in the flush cycle is
//    dropped even if handshaken. flush_in overrides accept and ex_ready_in; flush & rst -> reset wins.
//  - Decode (combinational, pre-register): opcodes LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP,
//    FENCE(=NOP), SYSTEM(=NOP). Others, or bad funct3/funct7 on OP/OP-IMM shifts -> illegal_out=1,
//    reg_write/mem_read/mem_write/branch/jump=0; still issued with valid_out=1 for trap handling.
//  - Imm: I=sext(i[31:20]); S=sext({i[31:25],i[11:7]}); B=sext({i[31],i[7],i[30:25],i[11:8],0});
//    U={i[31:12],12'b0}; J=sext({i[31],i[19:12],i[20],i[30:21],0}). All sign-extended from bit 31.
//  - SUB/SRA selected by instr[30] on OP; SRAI by instr[30] on OP-IMM. LUI -> ALU_PASSB.
// STRUCTURE
//  - Package decode_pkg: opcode localparams, alu_op_e enum (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,
//    PASSB), imm_type_e enum, ctrl_bundle_t packed struct (all bundle outputs) used for output reg and skid.
//  - Sub-module imm_gen: instr + imm_type_e -> imm (pure combinational).
//  - decode_stage: decoder case, output reg, skid reg, handshake/flush control.
// TESTING
//  - addi x1,x2,5 (0x00510093), ex_ready=1 -> next cycle valid_out=1, rd=1, rs1=2, imm=5, ALU_ADD,
//    alu_src_imm=1, reg_write=1.
//  - sw x5,-4(x2) (0xFE512E23) -> imm_out=0xFFFFFFFC, mem_write=1, mem_size=3'b010, reg_write=0.
//  - Two back-to-back instrs, ex_ready low 3 cycles -> first held stable, second in skid, ready_out=0;
//    ex_ready high -> issued in order on consecutive cycles, ready_out=1 again.
//  - flush_in with output+skid full and new input presented -> next cycle valid_out=0, ready_out=1,
//    none of the three instructions ever appears on outputs.
//  - instr 0x00000000 -> valid_out=1, illegal_out=1, all write/mem/branch flags 0; addi x0,x0,0 ->
//    reg_write=0.
//  - rst_in asserted mid-stall -> all outputs 0, valid_out=0; first post-reset instr decoded correctly.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV32I decode stage.
package decode_pkg;

   localparam int unsigned ILEN    = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned ALU_W   = 4;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [ALU_W-1:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_type_e;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [REG_AW-1:0] rd_addr;
      logic [DATA_W-1:0] imm;
      alu_op_e           alu_op;
      logic              alu_src_imm;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic [2:0]        mem_size;
      logic              branch;
      logic              jump;
      logic              illegal;
   } ctrl_bundle_t;

   // alt selects SUB/SRA; callers gate it for the opcodes where instr[30] is an imm bit
   function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: selects and sign-extends the RV32I immediate format.
module decode_stage_imm_gen
   import decode_pkg::*;
(
   input  logic [ILEN-1:0]   instr,
   input  imm_type_e         imm_type,
   output logic [DATA_W-1:0] imm_c
);

   always_comb begin
      imm_c = '0;
      case (imm_type)
         IMM_I:   imm_c = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm_c = {instr[31:12], 12'b0};
         IMM_J:   imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm_c = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a registered control bundle,
// valid/ready on both sides with a one-entry skid buffer and branch flush.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned SKID_EN = 1
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            instr_valid_in,
   input  logic [31:0]     instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            ready_out,
   input  logic            flush_in,
   input  logic            ex_ready_in,
   output logic            valid_out,
   output logic [XLEN-1:0] pc_out,
   output logic [4:0]      rs1_addr_out,
   output logic [4:0]      rs2_addr_out,
   output logic [4:0]      rd_addr_out,
   output logic [XLEN-1:0] imm_out,
   output logic [3:0]      alu_op_out,
   output logic            alu_src_imm_out,
   output logic            reg_write_out,
   output logic            mem_read_out,
   output logic            mem_write_out,
   output logic [2:0]      mem_size_out,
   output logic            branch_out,
   output logic            jump_out,
   output logic            illegal_out
);

   ctrl_bundle_t dec_ctrl, dec, out_q, skid_q;
   logic         out_valid, skid_valid;
   imm_type_e    imm_type;
   logic         legal;
   logic [DATA_W-1:0] imm_c;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;

   assign opcode = instr_in[6:0];
   assign funct3 = instr_in[14:12];
   assign funct7 = instr_in[31:25];

   decode_stage_imm_gen u_imm_gen (
      .instr    (instr_in),
      .imm_type (imm_type),
      .imm_c    (imm_c)
   );

   // Opcode/funct decode; illegal encodings still issue, with all side effects cleared
   always_comb begin
      dec_ctrl          = '0;
      imm_type          = IMM_NONE;
      legal             = 1'b1;
      dec_ctrl.pc       = DATA_W'(pc_in);
      dec_ctrl.rs1_addr = instr_in[19:15];
      dec_ctrl.rs2_addr = instr_in[24:20];
      dec_ctrl.rd_addr  = instr_in[11:7];
      dec_ctrl.alu_op   = ALU_ADD;
      case (opcode)
         OPC_LUI: begin
            imm_type             = IMM_U;
            dec_ctrl.alu_op      = ALU_PASSB;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_ctrl.reg_write   = 1'b1;
         end
         OPC_AUIPC: begin
            imm_type             = IMM_U;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_ctrl.reg_write   = 1'b1;
         end
         OPC_JAL: begin
            imm_type           = IMM_J;
            dec_ctrl.jump      = 1'b1;
            dec_ctrl.reg_write = 1'b1;
         end
         OPC_JALR: begin
            imm_type             = IMM_I;
            dec_ctrl.jump        = 1'b1;
            dec_ctrl.reg_write   = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
         end
         OPC_BRANCH: begin
            imm_type        = IMM_B;
            dec_ctrl.branch = 1'b1;
            dec_ctrl.alu_op = ALU_SUB;
         end
         OPC_LOAD: begin
            imm_type             = IMM_I;
            dec_ctrl.mem_read    = 1'b1;
            dec_ctrl.reg_write   = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_ctrl.mem_size    = funct3;
         end
         OPC_STORE: begin
            imm_type             = IMM_S;
            dec_ctrl.mem_write   = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_ctrl.mem_size    = funct3;
         end
         OPC_OP_IMM: begin
            imm_type             = IMM_I;
            dec_ctrl.reg_write   = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_ctrl.alu_op      = alu_from_funct3(funct3, (funct3 == 3'b101) && instr_in[30]);
            if (funct3 == 3'b001)
               legal = (funct7 == F7_BASE);
            else if (funct3 == 3'b101)
               legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
         end
         OPC_OP: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = alu_from_funct3(funct3, instr_in[30]);
            legal = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OPC_FENCE, OPC_SYSTEM: begin
            legal = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec_ctrl.reg_write = 1'b0;
         dec_ctrl.mem_read  = 1'b0;
         dec_ctrl.mem_write = 1'b0;
         dec_ctrl.mem_size  = '0;
         dec_ctrl.branch    = 1'b0;
         dec_ctrl.jump      = 1'b0;
         dec_ctrl.illegal   = 1'b1;
      end
      if (dec_ctrl.rd_addr == '0)
         dec_ctrl.reg_write = 1'b0;
   end

   always_comb begin
      dec     = dec_ctrl;
      dec.imm = imm_c;
   end

   logic accept, out_load;

   assign ready_out = (SKID_EN != 0) ? !skid_valid : (ex_ready_in || !out_valid);
   assign accept    = instr_valid_in && ready_out;
   assign out_load  = !out_valid || ex_ready_in;

   // Output register drains the skid first so issue order always matches accept order
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         out_q      <= '0;
         out_valid  <= 1'b0;
         skid_q     <= '0;
         skid_valid <= 1'b0;
      end else if (flush_in) begin
         out_q      <= '0;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (out_load) begin
         if (skid_valid) begin
            out_q     <= skid_q;
            out_valid <= 1'b1;
         end else begin
            if (accept)
               out_q <= dec;
            out_valid <= accept;
         end
         skid_valid <= 1'b0;
      end else if (accept && (SKID_EN != 0)) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign valid_out       = out_valid;
   assign pc_out          = XLEN'(out_q.pc);
   assign rs1_addr_out    = out_q.rs1_addr;
   assign rs2_addr_out    = out_q.rs2_addr;
   assign rd_addr_out     = out_q.rd_addr;
   assign imm_out         = XLEN'(signed'(out_q.imm));
   assign alu_op_out      = 4'(out_q.alu_op);
   assign alu_src_imm_out = out_q.alu_src_imm;
   assign reg_write_out   = out_q.reg_write;
   assign mem_read_out    = out_q.mem_read;
   assign mem_write_out   = out_q.mem_write;
   assign mem_size_out    = out_q.mem_size;
   assign branch_out      = out_q.branch;
   assign jump_out        = out_q.jump;
   assign illegal_out     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of decode vectors, scoreboard queue of issued bundles,
// plus stall/skid, flush and mid-stall reset sequences.
module tb_decode_stage;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_in, instr_valid_in, flush_in, ex_ready_in;
   logic [31:0] instr_in, pc_in;
   logic        ready_out, valid_out;
   logic [31:0] pc_out, imm_out;
   logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
   logic [3:0]  alu_op_out;
   logic        alu_src_imm_out, reg_write_out, mem_read_out, mem_write_out;
   logic [2:0]  mem_size_out;
   logic        branch_out, jump_out, illegal_out;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .SKID_EN(1)) dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .instr_valid_in  (instr_valid_in),
      .instr_in        (instr_in),
      .pc_in           (pc_in),
      .ready_out       (ready_out),
      .flush_in        (flush_in),
      .ex_ready_in     (ex_ready_in),
      .valid_out       (valid_out),
      .pc_out          (pc_out),
      .rs1_addr_out    (rs1_addr_out),
      .rs2_addr_out    (rs2_addr_out),
      .rd_addr_out     (rd_addr_out),
      .imm_out         (imm_out),
      .alu_op_out      (alu_op_out),
      .alu_src_imm_out (alu_src_imm_out),
      .reg_write_out   (reg_write_out),
      .mem_read_out    (mem_read_out),
      .mem_write_out   (mem_write_out),
      .mem_size_out    (mem_size_out),
      .branch_out      (branch_out),
      .jump_out        (jump_out),
      .illegal_out     (illegal_out)
   );

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      alu_op_e     alu;
      logic        src, rw, mr, mw;
      logic [2:0]  size;
      logic        br, jmp, ill;
      logic        chk_misc, chk_imm;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] pc;
   } sb_t;

   localparam int NV = 16;
   localparam int V_ADDI = 0, V_SW = 1, V_ZERO = 2, V_NOP = 3, V_LUI = 4, V_SUB = 5;

   vec_t vecs [NV];
   sb_t  sbq [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic [31:0] instr, input logic [4:0] rd, rs1, rs2,
                               input logic [31:0] imm, input alu_op_e alu, input logic src, rw, mr, mw,
                               input logic [2:0] size, input logic br, jmp, ill, chk_misc, chk_imm);
      vec_t v;
      v.instr = instr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.alu = alu;
      v.src = src; v.rw = rw; v.mr = mr; v.mw = mw; v.size = size;
      v.br = br; v.jmp = jmp; v.ill = ill; v.chk_misc = chk_misc; v.chk_imm = chk_imm;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_bundle(input sb_t e);
      vec_t  x;
      string p;
      x = vecs[e.idx];
      p = $sformatf("v%0d", e.idx);
      chk({p, ".pc"},      pc_out, e.pc);
      chk({p, ".rd"},      32'(rd_addr_out), 32'(x.rd));
      chk({p, ".rs1"},     32'(rs1_addr_out), 32'(x.rs1));
      chk({p, ".rs2"},     32'(rs2_addr_out), 32'(x.rs2));
      chk({p, ".rw"},      32'(reg_write_out), 32'(x.rw));
      chk({p, ".mr"},      32'(mem_read_out), 32'(x.mr));
      chk({p, ".mw"},      32'(mem_write_out), 32'(x.mw));
      chk({p, ".br"},      32'(branch_out), 32'(x.br));
      chk({p, ".jmp"},     32'(jump_out), 32'(x.jmp));
      chk({p, ".illegal"}, 32'(illegal_out), 32'(x.ill));
      if (x.mr || x.mw)
         chk({p, ".size"}, 32'(mem_size_out), 32'(x.size));
      if (x.chk_imm)
         chk({p, ".imm"}, imm_out, x.imm);
      if (x.chk_misc) begin
         chk({p, ".alu_op"}, 32'(alu_op_out), 32'(x.alu));
         chk({p, ".src_imm"}, 32'(alu_src_imm_out), 32'(x.src));
      end
   endtask

   // One clock: drive at negedge, score the cycle's handshakes, return after the posedge
   task automatic step(input logic v, input int idx, input logic [31:0] pc,
                       input logic exr, input logic fl, input logic rs, output logic acc);
      sb_t e;
      @(negedge clk);
      rst_in         = rs;
      flush_in       = fl;
      ex_ready_in    = exr;
      instr_valid_in = v;
      instr_in       = (idx >= 0) ? vecs[idx].instr : 32'h0;
      pc_in          = pc;
      #1;
      acc = v && ready_out && !fl && !rs;
      if (rs) begin
         sbq.delete();
      end else begin
         if (valid_out) begin
            if (sbq.size() == 0) begin
               chk("unexpected valid_out", 32'(valid_out), 32'h0);
            end else begin
               cmp_bundle(sbq[0]);
               if (exr && !fl) void'(sbq.pop_front());
            end
         end
         if (fl) sbq.delete();
         else if (acc) begin
            e.idx = idx;
            e.pc  = pc;
            sbq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      logic acc;
      for (int k = 0; k < 20 && sbq.size() != 0; k++)
         step(1'b0, -1, 32'h0, 1'b1, 1'b0, 1'b0, acc);
      chk("drain timeout", 32'(sbq.size()), 32'h0);
   endtask

   task automatic fill_two(input logic [31:0] pc);
      logic acc;
      step(1'b1, V_ADDI, pc, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, V_SW, pc + 32'h4, 1'b0, 1'b0, 1'b0, acc);
   endtask

   initial begin
      logic acc;
      vecs[0]  = mk(32'h00510093,  1,  2,  5, 32'h00000005, ALU_ADD,   1, 1, 0, 0, 3'd0, 0, 0, 0, 1, 1);
      vecs[1]  = mk(32'hFE512E23, 28,  2,  5, 32'hFFFFFFFC, ALU_ADD,   1, 0, 0, 1, 3'd2, 0, 0, 0, 1, 1);
      vecs[2]  = mk(32'h00000000,  0,  0,  0, 32'h0,        ALU_ADD,   0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 0);
      vecs[3]  = mk(32'h00000013,  0,  0,  0, 32'h00000000, ALU_ADD,   1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 1);
      vecs[4]  = mk(32'h123451B7,  3,  8,  3, 32'h12345000, ALU_PASSB, 1, 1, 0, 0, 3'd0, 0, 0, 0, 1, 1);
      vecs[5]  = mk(32'h407302B3,  5,  6,  7, 32'h00000000, ALU_SUB,   0, 1, 0, 0, 3'd0, 0, 0, 0, 1, 1);
      vecs[6]  = mk(32'h4030D093,  1,  1,  3, 32'h00000403, ALU_SRA,   1, 1, 0, 0, 3'd0, 0, 0, 0, 1, 1);
      vecs[7]  = mk(32'h40309093,  1,  1,  3, 32'h0,        ALU_ADD,   0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 0);
      vecs[8]  = mk(32'hFE208CE3, 25,  1,  2, 32'hFFFFFFF8, ALU_ADD,   0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 1);
      vecs[9]  = mk(32'h001000EF,  1,  0,  1, 32'h00000800, ALU_ADD,   0, 1, 0, 0, 3'd0, 0, 1, 0, 0, 1);
      vecs[10] = mk(32'hFFF5A503, 10, 11, 31, 32'hFFFFFFFF, ALU_ADD,   1, 1, 1, 0, 3'd2, 0, 0, 0, 1, 1);
      vecs[11] = mk(32'hFFFFF117,  2, 31, 31, 32'hFFFFF000, ALU_ADD,   1, 1, 0, 0, 3'd0, 0, 0, 0, 1, 1);
      vecs[12] = mk(32'h022080B3,  1,  1,  2, 32'h0,        ALU_ADD,   0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 0);
      vecs[13] = mk(32'h00000073,  0,  0,  0, 32'h0,        ALU_ADD,   0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
      vecs[14] = mk(32'h12345037,  0,  8,  3, 32'h12345000, ALU_PASSB, 1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 1);
      vecs[15] = mk(32'h0000007F,  0,  0,  0, 32'h0,        ALU_ADD,   0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 0);

      rst_in = 1'b1; instr_valid_in = 1'b0; flush_in = 1'b0; ex_ready_in = 1'b0;
      instr_in = '0; pc_in = '0;

      // Reset state
      step(1'b0, -1, 32'h0, 1'b0, 1'b0, 1'b1, acc);
      step(1'b0, -1, 32'h0, 1'b0, 1'b0, 1'b1, acc);
      chk("rst valid_out", 32'(valid_out), 32'h0);
      chk("rst pc_out", pc_out, 32'h0);
      chk("rst imm_out", imm_out, 32'h0);
      chk("rst rd_addr", 32'(rd_addr_out), 32'h0);
      chk("rst reg_write", 32'(reg_write_out), 32'h0);
      chk("rst illegal", 32'(illegal_out), 32'h0);
      step(1'b0, -1, 32'h0, 1'b1, 1'b0, 1'b0, acc);
      chk("ready after reset", 32'(ready_out), 32'h1);

      // Single addi: one-cycle latency, then idle
      step(1'b1, V_ADDI, 32'h100, 1'b1, 1'b0, 1'b0, acc);
      chk("addi latency valid", 32'(valid_out), 32'h1);
      step(1'b0, -1, 32'h0, 1'b1, 1'b0, 1'b0, acc);
      chk("addi issued once", 32'(valid_out), 32'h0);

      // Table back-to-back with execute always ready
      for (int i = 0; i < NV; i++) begin
         step(1'b1, i, 32'h1000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, acc);
         chk($sformatf("v%0d accepted", i), 32'(acc), 32'h1);
      end
      drain();

      // Two back-to-back then 3-cycle stall with a third presented and refused
      fill_two(32'h200);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, V_LUI, 32'h208, 1'b0, 1'b0, 1'b0, acc);
         chk("stall ready_out", 32'(ready_out), 32'h0);
         chk("stall valid_out", 32'(valid_out), 32'h1);
      end
      step(1'b0, -1, 32'h0, 1'b1, 1'b0, 1'b0, acc);
      chk("skid issued valid", 32'(valid_out), 32'h1);
      chk("skid drained ready", 32'(ready_out), 32'h1);
      step(1'b0, -1, 32'h0, 1'b1, 1'b0, 1'b0, acc);
      chk("stall seq done", 32'(valid_out), 32'h0);
      chk("stall seq queue", 32'(sbq.size()), 32'h0);

      // Flush with output + skid full and a new input handshaken-looking
      fill_two(32'h300);
      step(1'b1, V_LUI, 32'h308, 1'b1, 1'b1, 1'b0, acc);
      chk("flush valid_out", 32'(valid_out), 32'h0);
      chk("flush ready_out", 32'(ready_out), 32'h1);
      for (int k = 0; k < 2; k++) begin
         step(1'b0, -1, 32'h0, 1'b1, 1'b0, 1'b0, acc);
         chk("post-flush idle", 32'(valid_out), 32'h0);
      end
      // Flush drops an input accepted in the same cycle
      step(1'b1, V_SUB, 32'h310, 1'b1, 1'b1, 1'b0, acc);
      chk("flush drops input", 32'(valid_out), 32'h0);

      // Reset in the middle of a stall
      fill_two(32'h400);
      step(1'b1, V_LUI, 32'h408, 1'b0, 1'b0, 1'b1, acc);
      chk("mid rst valid_out", 32'(valid_out), 32'h0);
      chk("mid rst pc_out", pc_out, 32'h0);
      chk("mid rst imm_out", imm_out, 32'h0);
      chk("mid rst rd_addr", 32'(rd_addr_out), 32'h0);
      chk("mid rst mem_write", 32'(mem_write_out), 32'h0);
      chk("mid rst ready_out", 32'(ready_out), 32'h1);
      step(1'b1, V_ADDI, 32'h500, 1'b1, 1'b0, 1'b0, acc);
      chk("post-rst valid", 32'(valid_out), 32'h1);
      drain();
      step(1'b0, -1, 32'h0, 1'b1, 1'b0, 1'b0, acc);
      chk("no skid ghost after rst", 32'(valid_out), 32'h0);

      // Random execute backpressure over the whole table
      for (int i = 0; i < NV; i++) begin
         int tries;
         tries = 0;
         acc   = 1'b0;
         while (!acc && tries < 50) begin
            step(1'b1, i, 32'h2000 + 32'(4 * i), 1'($urandom_range(0, 1)), 1'b0, 1'b0, acc);
            tries++;
         end
         chk($sformatf("rand v%0d accept", i), 32'(acc), 32'h1);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
